// File: rtl/bf16_pkg.sv
// Shared bfloat16 types, constants and operand classification for the
// pipelined multiplier.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam int          BF16_BIAS    = 127;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } bf16_cls_t;

    // Stage-1 register contents: the exponent is a 10-bit two's-complement value.
    typedef struct packed {
        logic       sign;
        logic [9:0] exp;
        logic [15:0] prod;
        bf16_cls_t  cls;
    } bf16_s1_t;

    // Subnormals classify as zero: they are flushed before any arithmetic.
    function automatic bf16_cls_t bf16_classify(input bf16_t x);
        bf16_cls_t cls;
        cls = CLS_NORM;
        if (x.exp == 8'h00) begin
            cls = CLS_ZERO;
        end else if (x.exp == BF16_EXP_MAX) begin
            cls = (x.man == 7'h00) ? CLS_INF : CLS_NAN;
        end
        return cls;
    endfunction

    function automatic bf16_cls_t bf16_mul_class(input bf16_cls_t ca, input bf16_cls_t cb);
        bf16_cls_t cls;
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
            cls = CLS_NAN;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            cls = CLS_INF;
        end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/bfloat_mul_lane.sv
// One bfloat16 multiplier lane: S1 unpacks and multiplies, S2 normalizes,
// rounds (RNE) and packs. Optional flags output under BF16_MUL_FLAGS_EN.
module bfloat_mul_lane
    import bf16_pkg::*;
(
    input  logic        clk1,
    input  logic        s1_en,
    input  logic        s2_en,
    input  logic [15:0] a,
    input  logic [15:0] b,
`ifdef BF16_MUL_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic [15:0] c
);

    bf16_t     op_a;
    bf16_t     op_b;
    bf16_s1_t  s1_d;
    bf16_s1_t  s1_q;

    assign op_a = bf16_t'(a);
    assign op_b = bf16_t'(b);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = op_a.sign ^ op_b.sign;
        s1_d.exp  = {2'b00, op_a.exp} + {2'b00, op_b.exp} - 10'(BF16_BIAS);
        s1_d.prod = 16'({1'b1, op_a.man}) * 16'({1'b1, op_b.man});
        s1_d.cls  = bf16_mul_class(bf16_classify(op_a), bf16_classify(op_b));
    end

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    // NOTE: datapath registers carry no reset; the top masks them with the stage valid bits.
    always_ff @(posedge clk1) begin
        if (s1_en) s1_q <= s1_d;
    end

    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [6:0]        frac;
    logic [6:0]        frac_r;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [8:0]        man_r;
    logic              ovf;
    logic              unf;
    bf16_t             res;
    bf16_t             c_q;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        exp_n  = $signed(s1_q.exp);
        frac   = s1_q.prod[13:7];
        guard  = s1_q.prod[6];
        sticky = |s1_q.prod[5:0];
        if (s1_q.prod[15]) begin
            exp_n  = $signed(s1_q.exp) + 10'sd1;
            frac   = s1_q.prod[14:8];
            guard  = s1_q.prod[7];
            sticky = |s1_q.prod[6:0];
        end

        round_up = guard && (sticky || frac[0]);
        man_r    = {2'b01, frac} + {8'd0, round_up};
        // A carry out of 1.1111111 leaves 10.0000000: shift right, bump exponent.
        exp_r    = man_r[8] ? exp_n + 10'sd1 : exp_n;
        frac_r   = man_r[8] ? man_r[7:1] : man_r[6:0];
        ovf      = (exp_r >= 10'sd255);
        unf      = (exp_r <= 10'sd0);

        res      = '0;
        res.sign = s1_q.sign;
        unique case (s1_q.cls)
            CLS_NAN:  res = bf16_t'(BF16_QNAN);
            CLS_INF:  res.exp = BF16_EXP_MAX;
            CLS_ZERO: ;
            default: begin
                if (ovf) begin
                    res.exp = BF16_EXP_MAX;
                end else if (!unf) begin
                    res.exp = exp_r[7:0];
                    res.man = frac_r;
                end
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (s2_en) c_q <= res;
    end

    assign c = c_q;

`ifdef BF16_MUL_FLAGS_EN
    logic       sub_in_d;
    logic       sub_in_q;
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    assign sub_in_d = (op_a.exp == 8'h00 && op_a.man != 7'h00) ||
                      (op_b.exp == 8'h00 && op_b.man != 7'h00);

    always_ff @(posedge clk1) begin
        if (s1_en) sub_in_q <= sub_in_d;
    end

    // {invalid, overflow, underflow, inexact}
    always_comb begin
        flags_d    = '0;
        flags_d[3] = (s1_q.cls == CLS_NAN);
        if (s1_q.cls == CLS_NORM) begin
            flags_d[2] = ovf;
            flags_d[1] = unf;
            flags_d[0] = ovf || unf || guard || sticky;
        end else if (s1_q.cls == CLS_ZERO && sub_in_q) begin
            flags_d[1] = 1'b1;
            flags_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (s2_en) flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif

endmodule

// File: rtl/parameterization_mul_pipe.sv
// N-lane bfloat16 multiplier, two-stage valid/ready pipeline around per-lane
// datapaths. Defining BF16_MUL_FLAGS_EN adds a per-lane exception flags port.
module parameterization_mul_pipe
    import bf16_pkg::*;
#(
    parameter int N = 2
) (
    input  logic            clk1,
    input  logic            rst1,
    input  logic [16*N-1:0] a1,
    input  logic [16*N-1:0] b1,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [16*N-1:0] c1,
`ifdef BF16_MUL_FLAGS_EN
    output logic [4*N-1:0]  flags,
`endif
    output logic            out_valid,
    input  logic            out_ready
);

    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    logic s1_en;
    logic s2_en;

    // S2 frees up when empty or draining; S1 frees up when empty or advancing.
    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !rst1 && (!s1_valid || s2_ready);
    assign s1_en    = in_valid && in_ready;
    assign s2_en    = s1_valid && s2_ready;

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_en)          s1_valid <= 1'b1;
            else if (s2_en)     s1_valid <= 1'b0;

            if (s2_en)          s2_valid <= 1'b1;
            else if (out_ready) s2_valid <= 1'b0;
        end
    end

    logic [16*N-1:0] c_raw;
`ifdef BF16_MUL_FLAGS_EN
    logic [4*N-1:0]  flags_raw;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        bfloat_mul_lane u_lane (
            .clk1  (clk1),
            .s1_en (s1_en),
            .s2_en (s2_en),
            .a     (a1[16*i +: 16]),
            .b     (b1[16*i +: 16]),
`ifdef BF16_MUL_FLAGS_EN
            .flags (flags_raw[4*i +: 4]),
`endif
            .c     (c_raw[16*i +: 16])
        );
    end

    assign out_valid = s2_valid;
    assign c1        = s2_valid ? c_raw : '0;
`ifdef BF16_MUL_FLAGS_EN
    assign flags     = s2_valid ? flags_raw : '0;
`endif

endmodule

// File: tb/tb_parameterization_mul_pipe.sv
// Scoreboard bench for parameterization_mul_pipe (N=2): directed vectors,
// stall, mid-pipeline reset and a random stream against an RNE model.
module tb_parameterization_mul_pipe;

    logic        clk1 = 1'b0;
    logic        rst1 = 1'b1;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] c1;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef BF16_MUL_FLAGS_EN
    logic [7:0]  flags;
`endif

    parameterization_mul_pipe #(.N(2)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .a1        (a1),
        .b1        (b1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c1        (c1),
`ifdef BF16_MUL_FLAGS_EN
        .flags     (flags),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] c;
        logic [7:0]  f;
        logic        fchk;
        logic        lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent model: integer product, then generic shift-and-round.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, p, sh, q, rem, half, e;
        logic s;
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        ma = int'(a[6:0]);  mb = int'(b[6:0]);
        s  = a[15] ^ b[15];
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 16'h7FC0;
        if ((ea == 255 && eb == 0) || (ea == 0 && eb == 255)) return 16'h7FC0;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 7'h00};
        if (ea == 0 || eb == 0) return {s, 15'h0000};
        p    = (128 + ma) * (128 + mb);
        sh   = (p >= 32768) ? 8 : 7;
        e    = ea + eb - 127 + sh - 7;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 256) begin
            q = 128;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[7:0], q[6:0]};
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input exp_t e, input logic ordy,
                               output logic acc, output logic rdy, output logic ov,
                               output logic [31:0] cq);
        in_valid  = v;
        a1        = a;
        b1        = b;
        out_ready = ordy;
        @(negedge clk1);
        rdy = in_ready;
        ov  = out_valid;
        cq  = c1;
        acc = v && rdy;
        if (acc) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [7:0] f, input logic fchk, input logic lat,
                        input logic ordy, output logic acc);
        exp_t e;
        logic rdy, ov;
        logic [31:0] cq;
        e.c = c; e.f = f; e.fchk = fchk; e.lat = lat; e.cyc = 0;
        drive_cycle(1'b1, a, b, e, ordy, acc, rdy, ov, cq);
    endtask

    task automatic idle(input logic ordy, output logic rdy, output logic ov);
        exp_t e;
        logic acc;
        logic [31:0] cq;
        e.c = '0; e.f = '0; e.fchk = 1'b0; e.lat = 1'b0; e.cyc = 0;
        drive_cycle(1'b0, '0, '0, e, ordy, acc, rdy, ov, cq);
    endtask

    task automatic drain();
        logic rdy, ov;
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1, rdy, ov);
        idle(1'b1, rdy, ov);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk1) begin
        if (!rst1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got c1=%h, expected no output", c1);
            end else begin
                mon_e = sb.pop_front();
                check("c1", c1, mon_e.c);
                if (mon_e.lat) check("latency", 32'(cyc - mon_e.cyc), 32'd2);
`ifdef BF16_MUL_FLAGS_EN
                if (mon_e.fchk) check("flags", 32'(flags), 32'(mon_e.f));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] st_a [5];
    logic [31:0] st_b [5];
    logic [31:0] st_c [5];

    initial begin
        logic        acc, rdy, ov;
        logic [31:0] cq, held, ra, rb;
        logic [7:0]  rdy_pattern;
        int          idx;
        exp_t        e;

        // Reset state
        repeat (2) @(posedge clk1);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c1", c1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst1 = 1'b0;
        idle(1'b1, rdy, ov);
        check("post_rst_in_ready", 32'(rdy), 32'd1);

        // Directed vectors, back to back, hand-computed results and flags
        send(32'h3F80_4000, 32'h3F80_4040, 32'h3F80_40C0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        send(32'hBFC0_3F81, 32'h4000_3F81, 32'hC040_3F82, 8'h01, 1'b1, 1'b1, 1'b1, acc);
        send(32'h7F00_7F80, 32'h4000_0000, 32'h7F80_7FC0, 8'h58, 1'b1, 1'b1, 1'b1, acc);
        send(32'h0001_3F80, 32'h3F80_3F80, 32'h0000_3F80, 8'h30, 1'b1, 1'b1, 1'b1, acc);
        send(32'h3FB5_3F81, 32'h3FB5_3FC0, 32'h4000_3FC2, 8'h11, 1'b1, 1'b1, 1'b1, acc);
        send(32'h3F83_8000, 32'h3FC0_7F80, 32'h3FC4_7FC0, 8'h18, 1'b1, 1'b1, 1'b1, acc);
        send(32'hC000_8080, 32'h4000_3F00, 32'hC080_8000, 8'h03, 1'b1, 1'b1, 1'b1, acc);
        send(32'h7F80_8000, 32'hBF80_3F80, 32'hFF80_8000, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        drain();

        // Stall: out_ready low in cycles 3..5 of a 5-set stream
        st_a[0] = 32'h4040_3F80; st_b[0] = 32'h4000_4040; st_c[0] = 32'h40C0_4040;
        st_a[1] = 32'h4080_BF80; st_b[1] = 32'h4000_4000; st_c[1] = 32'h4100_C000;
        st_a[2] = 32'h3F00_4040; st_b[2] = 32'h3F00_4040; st_c[2] = 32'h3E80_4110;
        st_a[3] = 32'h40A0_C040; st_b[3] = 32'h4000_C040; st_c[3] = 32'h4120_4110;
        st_a[4] = 32'h3F80_0000; st_b[4] = 32'hC2C8_4000; st_c[4] = 32'hC2C8_0000;
        rdy_pattern = 8'hC7;
        idx  = 0;
        held = '0;
        for (int k = 0; k < 8; k++) begin
            e.c = st_c[(idx < 5) ? idx : 4]; e.f = '0; e.fchk = 1'b0; e.lat = 1'b0; e.cyc = 0;
            drive_cycle(idx < 5, st_a[(idx < 5) ? idx : 4], st_b[(idx < 5) ? idx : 4], e,
                        !(k >= 3 && k <= 5), acc, rdy, ov, cq);
            check("stall_in_ready", 32'(rdy), 32'(rdy_pattern[k]));
            if (k == 3) held = cq;
            if (k >= 4 && k <= 6) begin
                check("stall_out_valid_held", 32'(ov), 32'd1);
                check("stall_c1_held", cq, held);
            end
            if (acc) idx++;
        end
        check("stall_all_accepted", 32'(idx), 32'd5);
        drain();

        // Reset with both stages full
        send(32'h3F80_4000, 32'h3F80_4040, 32'h3F80_40C0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check("fill_s1_accept", 32'(acc), 32'd1);
        send(32'hBFC0_3F81, 32'h4000_3F81, 32'hC040_3F82, 8'h01, 1'b0, 1'b0, 1'b0, acc);
        check("fill_s2_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst1 = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_c1", c1, 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk1);
        #1;
        rst1 = 1'b0;
        idle(1'b1, rdy, ov);
        check("rst_release_in_ready", 32'(rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1, rdy, ov);
            check("no_stale_output", 32'(ov), 32'd0);
        end

        // Random back-to-back stream against the model
        for (int i = 0; i < 100; i++) begin
            ra = $urandom();
            rb = $urandom();
            send(ra, rb, {ref_mul(ra[31:16], rb[31:16]), ref_mul(ra[15:0], rb[15:0])},
                 8'h00, 1'b0, 1'b1, 1'b1, acc);
            check("no_bubble_accept", 32'(acc), 32'd1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
